// File: rtl/ipq_pkg.sv
// Shared defaults and field helpers for the instruction prefetch queue.
// Word layout: opcode in the MSBs, operand in the remaining LSBs.
package ipq_pkg;

  localparam int DEF_WORD_W = 8;
  localparam int DEF_OPC_W  = 4;
  localparam int DEF_DEPTH  = 4;
  localparam logic [DEF_WORD_W-1:0] DEF_NOP_WORD = 8'h01;
  localparam int OPR_W = DEF_WORD_W - DEF_OPC_W;

  // Width-generic field extraction on a 32-bit container; widths are elaboration constants.
  function automatic logic [31:0] opcode_field(input logic [31:0] word, input int word_w,
                                               input int opc_w);
    return (word >> (word_w - opc_w)) & ((32'd1 << opc_w) - 32'd1);
  endfunction

  function automatic logic [31:0] operand_field(input logic [31:0] word, input int word_w,
                                                input int opc_w);
    return word & ((32'd1 << (word_w - opc_w)) - 32'd1);
  endfunction

endpackage

// File: rtl/ipq_fifo_core.sv
// Generic synchronous FIFO: DEPTH x WIDTH storage, wrapping pointers, occupancy count.
// A push into a full FIFO is accepted only when a pop retires the head in the same cycle.
module ipq_fifo_core #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  import ipq_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_s, empty_s, do_push_s, do_pop_s;

  // Qualify requests against occupancy and compute next storage/pointer state.
  always_comb begin
    empty_s   = (count_q == CNT_W'(1'b0));
    full_s    = (count_q == CNT_W'(DEPTH));
    do_pop_s  = pop && !empty_s;
    do_push_s = push && (!full_s || do_pop_s);
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (do_push_s) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1'b1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1'b1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CNT_W'(1'b1);
      2'b01:   count_d = count_q - CNT_W'(1'b1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (clear) begin
      wr_ptr_q <= PTR_W'(1'b0);
      rd_ptr_q <= PTR_W'(1'b0);
      count_q  <= CNT_W'(1'b0);
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible once counted.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = full_s;
  assign empty = empty_s;

endmodule

// File: rtl/instruction_prefetch_queue.sv
// Instruction prefetch queue: buffers fetched words, presents head opcode, drives head operand.
// Optional feature macro IPQ_OPERAND_SEXT_EN: sign-extend the operand onto the bus upper bits.
module instruction_prefetch_queue #(
  parameter int WORD_W = ipq_pkg::DEF_WORD_W,
  parameter int OPC_W  = ipq_pkg::DEF_OPC_W,
  parameter int DEPTH  = ipq_pkg::DEF_DEPTH,
  parameter logic [WORD_W-1:0] NOP_WORD = WORD_W'(ipq_pkg::DEF_NOP_WORD)
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              n_load,
  input  logic              n_advance,
  input  logic              n_enable,
  inout  wire  [WORD_W-1:0] bus,
  output logic [OPC_W-1:0]  opcode,
  output logic              empty,
  output logic              full,
  output logic              overflow
);
  import ipq_pkg::*;

  localparam int FIELD_W = WORD_W - OPC_W;
  localparam logic [OPC_W-1:0] NOP_OPC = NOP_WORD[WORD_W-1 -: OPC_W];

  logic               push_req_s, pop_req_s, drive_s;
  logic               fifo_full_s, fifo_empty_s;
  logic [WORD_W-1:0]  head_word_s;
  logic [OPC_W-1:0]   head_opcode_s;
  logic [FIELD_W-1:0] head_operand_s;
  logic               overflow_q, overflow_d;

  ipq_fifo_core #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .clear (clear),
    .push  (push_req_s),
    .pop   (pop_req_s),
    .wdata (bus),
    .rdata (head_word_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // A load while this block drives the bus would capture its own operand, so it is suppressed.
  always_comb begin
    push_req_s     = !n_load && n_enable;
    pop_req_s      = !n_advance;
    drive_s        = !n_enable && !fifo_empty_s;
    head_opcode_s  = OPC_W'(opcode_field(32'(head_word_s), WORD_W, OPC_W));
    head_operand_s = FIELD_W'(operand_field(32'(head_word_s), WORD_W, OPC_W));
    overflow_d     = overflow_q;
    if (push_req_s && fifo_full_s && !pop_req_s) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // Sticky overflow flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (clear) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  // Status outputs and NOP substitution while empty.
  always_comb begin
    empty    = fifo_empty_s;
    full     = fifo_full_s;
    overflow = overflow_q;
    opcode   = NOP_OPC;
    if (fifo_empty_s) begin
      opcode = NOP_OPC;
    end else begin
      opcode = head_opcode_s;
    end
  end

  assign bus[FIELD_W-1:0] = drive_s ? head_operand_s : {FIELD_W{1'bz}};

`ifdef IPQ_OPERAND_SEXT_EN
  assign bus[WORD_W-1:FIELD_W] = drive_s ? {OPC_W{head_operand_s[FIELD_W-1]}} : {OPC_W{1'bz}};
`else
  assign bus[WORD_W-1:FIELD_W] = {OPC_W{1'bz}};
`endif

endmodule

// File: tb/tb_instruction_prefetch_queue.sv
// Directed self-checking bench for instruction_prefetch_queue (DEPTH=4, 8-bit words).
module tb_instruction_prefetch_queue;

  logic       clk = 1'b0;
  logic       clear, n_load, n_advance, n_enable;
  logic [7:0] drv_val;
  logic       drv_hi_en, drv_lo_en;
  wire  [7:0] bus;
  logic [3:0] opcode;
  logic       empty, full, overflow;
  int         n_total = 0;
  int         n_pass  = 0;

  // Bench bus drivers; a released DUT lets the bench value through unchanged.
  assign bus[7:4] = drv_hi_en ? drv_val[7:4] : 4'bzzzz;
  assign bus[3:0] = drv_lo_en ? drv_val[3:0] : 4'bzzzz;

  always #5 clk = ~clk;

  instruction_prefetch_queue dut (
    .clk       (clk),
    .clear     (clear),
    .n_load    (n_load),
    .n_advance (n_advance),
    .n_enable  (n_enable),
    .bus       (bus),
    .opcode    (opcode),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    clear     = 1'b0;
    n_load    = 1'b1;
    n_advance = 1'b1;
    n_enable  = 1'b1;
    drv_hi_en = 1'b0;
    drv_lo_en = 1'b0;
    drv_val   = 8'h00;
  endtask

  task automatic push(input logic [7:0] w);
    idle();
    n_load    = 1'b0;
    drv_hi_en = 1'b1;
    drv_lo_en = 1'b1;
    drv_val   = w;
    step();
    idle();
  endtask

  task automatic pop();
    idle();
    n_advance = 1'b0;
    step();
    idle();
  endtask

  task automatic chk_released(input string tag);
    n_enable  = 1'b0;
    drv_hi_en = 1'b1;
    drv_lo_en = 1'b1;
    drv_val   = 8'h00;
    #1;
    chk(tag, bus, 8'h00);
    idle();
  endtask

  // Head operand drive: bench holds the upper nibble at 0 unless the extension owns it.
  task automatic chk_drive(input string tag, input logic [7:0] exp);
    n_enable  = 1'b0;
    drv_lo_en = 1'b0;
    drv_val   = 8'h00;
`ifdef IPQ_OPERAND_SEXT_EN
    drv_hi_en = 1'b0;
`else
    drv_hi_en = 1'b1;
`endif
    #1;
    chk(tag, bus, exp);
    idle();
  endtask

  initial begin
    idle();
    clear = 1'b1;
    step();
    idle();
    chk("rst_opcode", {4'h0, opcode}, 8'h00);
    chk("rst_empty", {7'h0, empty}, 8'h01);
    chk("rst_full", {7'h0, full}, 8'h00);
    chk("rst_overflow", {7'h0, overflow}, 8'h00);
    chk_released("rst_bus_released");

    push(8'h3A);
    chk("first_push_opcode", {4'h0, opcode}, 8'h03);
    chk("first_push_empty", {7'h0, empty}, 8'h00);
    push(8'h5C);
    chk("second_push_head", {4'h0, opcode}, 8'h03);
    pop();
    chk("pop1_opcode", {4'h0, opcode}, 8'h05);
    pop();
    chk("pop2_empty", {7'h0, empty}, 8'h01);
    chk("pop2_nop", {4'h0, opcode}, 8'h00);
    pop();
    chk("pop_empty_empty", {7'h0, empty}, 8'h01);
    chk("pop_empty_full", {7'h0, full}, 8'h00);

    push(8'h1F);
    push(8'h2E);
    push(8'h3D);
    chk("three_not_full", {7'h0, full}, 8'h00);
    push(8'h4C);
    chk("four_full", {7'h0, full}, 8'h01);
    chk("four_no_overflow", {7'h0, overflow}, 8'h00);
    push(8'h5B);
    chk("drop_full", {7'h0, full}, 8'h01);
    chk("drop_overflow", {7'h0, overflow}, 8'h01);
    chk("fifo_head0", {4'h0, opcode}, 8'h01);
    pop();
    chk("fifo_head1", {4'h0, opcode}, 8'h02);
    pop();
    chk("fifo_head2", {4'h0, opcode}, 8'h03);
    pop();
    chk("fifo_head3", {4'h0, opcode}, 8'h04);
    pop();
    chk("fifo_drained", {7'h0, empty}, 8'h01);
    chk("overflow_sticky", {7'h0, overflow}, 8'h01);
    chk_released("empty_bus_released");

    clear = 1'b1;
    step();
    idle();
    chk("clear_overflow", {7'h0, overflow}, 8'h00);

    push(8'hA1);
    push(8'hB2);
    push(8'hC3);
    push(8'hD4);
    chk("full_again", {7'h0, full}, 8'h01);
    n_load    = 1'b0;
    n_advance = 1'b0;
    drv_hi_en = 1'b1;
    drv_lo_en = 1'b1;
    drv_val   = 8'hE7;
    step();
    idle();
    chk("pushpop_full", {7'h0, full}, 8'h01);
    chk("pushpop_no_overflow", {7'h0, overflow}, 8'h00);
    chk("pushpop_head", {4'h0, opcode}, 8'h0B);
    pop();
    chk("pushpop_head_c", {4'h0, opcode}, 8'h0C);
    pop();
    chk("pushpop_head_d", {4'h0, opcode}, 8'h0D);
    pop();
    chk("pushpop_head_e", {4'h0, opcode}, 8'h0E);
    chk_drive("drive_e7", 8'h07);
    pop();
    chk("pushpop_drained", {7'h0, empty}, 8'h01);

    push(8'h2B);
`ifdef IPQ_OPERAND_SEXT_EN
    chk_drive("drive_2b", 8'hFB);
`else
    chk_drive("drive_2b", 8'h0B);
`endif
    pop();
    push(8'h25);
    chk_drive("drive_25", 8'h05);
    pop();

    push(8'h61);
    push(8'h72);
    push(8'h83);
    push(8'h94);
    push(8'hA5);
    chk("pre_clear_overflow", {7'h0, overflow}, 8'h01);
    pop();
    chk("pre_clear_head", {4'h0, opcode}, 8'h07);
    clear     = 1'b1;
    n_load    = 1'b0;
    n_advance = 1'b0;
    drv_hi_en = 1'b1;
    drv_lo_en = 1'b1;
    drv_val   = 8'hC6;
    step();
    idle();
    chk("clear_prio_empty", {7'h0, empty}, 8'h01);
    chk("clear_prio_overflow", {7'h0, overflow}, 8'h00);
    chk("clear_prio_opcode", {4'h0, opcode}, 8'h00);
    chk("clear_prio_full", {7'h0, full}, 8'h00);
    n_load   = 1'b0;
    n_enable = 1'b0;
    step();
    idle();
    chk("self_load_suppressed", {7'h0, empty}, 8'h01);
    push(8'hD8);
    chk("post_clear_push", {4'h0, opcode}, 8'h0D);
    chk("post_clear_not_empty", {7'h0, empty}, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
